// File: rtl/gpio_wb_slave.sv
// -----------------------------------------------------------------------------
// gpio_wb_slave
//
// Wishbone B4 classic slave register block for the GPIO core. It holds the pad
// output and direction registers, synchronises the pad inputs and, when the
// interrupt feature is built in, detects edges and raises a level interrupt.
//
// Register map (wb_adr_i[4:2]):
//   0 DATA_IN    RO    synchronised gpio_i
//   1 DATA_OUT   RW    drives gpio_o
//   2 DIR        RW    drives gpio_oe (1 = output)
//   3 INT_EN     RW    interrupt enable per pin
//   4 INT_POL    RW    1 = rising edge, 0 = falling edge
//   5 INT_STATUS RW1C  edge capture, write 1 to clear
//   6,7                read 0, writes dropped, still acked
//
// Optional feature macro: GPIO_IRQ_EN
//   defined   : INT_EN / INT_POL / INT_STATUS, edge detect and irq_o present.
//   undefined : those registers read 0 and ignore writes, irq_o tied 0.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   wb_cyc_i   bus cycle valid
//   wb_stb_i   strobe
//   wb_we_i    1 = write, 0 = read
//   wb_adr_i   byte address, only [4:2] decoded
//   wb_dat_i   write data
//   wb_sel_i   byte lane enables
//   wb_dat_o   read data, valid only while wb_ack_o = 1, else 0
//   wb_ack_o   one-cycle transfer acknowledge
//   gpio_i     asynchronous pad inputs
//   gpio_o     pad output values (DATA_OUT)
//   gpio_oe    pad output enables (DIR)
//   irq_o      level interrupt, |(INT_STATUS & INT_EN) registered
// -----------------------------------------------------------------------------
module gpio_wb_slave #(
    parameter int          GPIO_WIDTH  = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] OUT_RESET   = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq_o
);

    logic                  r_ack;
    logic [31:0]           r_dat_o;
    logic [GPIO_WIDTH-1:0] r_data_out;
    logic [GPIO_WIDTH-1:0] r_dir;
    logic [GPIO_WIDTH-1:0] r_sync [SYNC_STAGES];

    logic                  w_req;
    logic                  w_wr;
    logic [2:0]            w_adr;
    logic [31:0]           w_lane_mask;
    logic [GPIO_WIDTH-1:0] w_wmask;
    logic [GPIO_WIDTH-1:0] w_wdata;
    logic [GPIO_WIDTH-1:0] w_data_in;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    // Only adr[4:2] is decoded; the rest of the address is intentionally ignored.
    assign w_unused = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i, w_lane_mask};

    // A request is only taken while no ack is outstanding, so a held
    // cyc/stb is acknowledged every second cycle.
    assign w_req = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr  = w_req & wb_we_i;
    assign w_adr = wb_adr_i[4:2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_mask[gi*8 +: 8] = {8{wb_sel_i[gi]}};
        end
    endgenerate

    // Bits at or above GPIO_WIDTH are simply not stored.
    assign w_wmask   = w_lane_mask[GPIO_WIDTH-1:0];
    assign w_wdata   = wb_dat_i[GPIO_WIDTH-1:0];
    assign w_data_in = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Pad input synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output and direction registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= OUT_RESET[GPIO_WIDTH-1:0];
            r_dir      <= '0;
        end else if (w_wr) begin
            if (w_adr == 3'd1) begin
                r_data_out <= (r_data_out & ~w_wmask) | (w_wdata & w_wmask);
            end
            if (w_adr == 3'd2) begin
                r_dir <= (r_dir & ~w_wmask) | (w_wdata & w_wmask);
            end
        end
    end

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] r_int_en;
    logic [GPIO_WIDTH-1:0] r_int_pol;
    logic [GPIO_WIDTH-1:0] r_int_status;
    logic [GPIO_WIDTH-1:0] r_data_in_prev;
    logic                  r_irq;
    logic [GPIO_WIDTH-1:0] w_edge;
    logic [GPIO_WIDTH-1:0] w_w1c;

    // Qualifying edge: rising where POL=1, falling where POL=0. Edges are
    // taken from the synchronised value only, so a POL write cannot fake one.
    assign w_edge = (w_data_in & ~r_data_in_prev & r_int_pol)
                  | (~w_data_in & r_data_in_prev & ~r_int_pol);
    assign w_w1c  = (w_wr && (w_adr == 3'd5)) ? (w_wdata & w_wmask) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_en       <= '0;
            r_int_pol      <= '0;
            r_int_status   <= '0;
            r_data_in_prev <= '0;
            r_irq          <= 1'b0;
        end else begin
            r_data_in_prev <= w_data_in;
            // New edge is OR'd in after the clear so it wins over W1C.
            r_int_status   <= (r_int_status & ~w_w1c) | w_edge;
            r_irq          <= |(r_int_status & r_int_en);
            if (w_wr && (w_adr == 3'd3)) begin
                r_int_en <= (r_int_en & ~w_wmask) | (w_wdata & w_wmask);
            end
            if (w_wr && (w_adr == 3'd4)) begin
                r_int_pol <= (r_int_pol & ~w_wmask) | (w_wdata & w_wmask);
            end
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read mux (current register contents, before any same-cycle write)
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (w_adr)
            3'd0: w_rdata[GPIO_WIDTH-1:0] = w_data_in;
            3'd1: w_rdata[GPIO_WIDTH-1:0] = r_data_out;
            3'd2: w_rdata[GPIO_WIDTH-1:0] = r_dir;
`ifdef GPIO_IRQ_EN
            3'd3: w_rdata[GPIO_WIDTH-1:0] = r_int_en;
            3'd4: w_rdata[GPIO_WIDTH-1:0] = r_int_pol;
            3'd5: w_rdata[GPIO_WIDTH-1:0] = r_int_status;
`endif
            default: w_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus response: ack and read data registered together
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ack   <= w_req;
            r_dat_o <= (w_req && !wb_we_i) ? w_rdata : '0;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat_o;
    assign gpio_o   = r_data_out;
    assign gpio_oe  = r_dir;

endmodule

// File: tb/tb_gpio_wb_slave.sv
`timescale 1ns/1ps
module tb_gpio_wb_slave;

    localparam int          GW   = 32;
    localparam int          SS   = 2;
    localparam logic [31:0] ORST = 32'h5A00_00C3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_i, dat_o;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] gpio_in, gpio_o, gpio_oe;
    logic        irq;

    always #5 clk = ~clk;

    gpio_wb_slave #(
        .GPIO_WIDTH (GW),
        .SYNC_STAGES(SS),
        .OUT_RESET  (ORST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wb_cyc_i(cyc),
        .wb_stb_i(stb),
        .wb_we_i (we),
        .wb_adr_i(adr),
        .wb_dat_i(dat_i),
        .wb_sel_i(sel),
        .wb_dat_o(dat_o),
        .wb_ack_o(ack),
        .gpio_i  (gpio_in),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq_o   (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference: register file as plain variables, pad history
    // kept as a time-indexed array, DATA_IN = sample taken SS edges ago.
    // ------------------------------------------------------------------
    logic [31:0] m_out, m_dir, m_en, m_pol, m_stat, m_prev, m_dat;
    logic        m_ack, m_irq;
    logic [31:0] m_hist [16];
    int          m_cnt;

    always @(posedge clk) begin
        logic [31:0] din, rd, lane, wv;
        logic        req;
        if (rst) begin
            m_out  <= ORST;
            m_dir  <= '0;
            m_en   <= '0;
            m_pol  <= '0;
            m_stat <= '0;
            m_prev <= '0;
            m_ack  <= 1'b0;
            m_dat  <= '0;
            m_irq  <= 1'b0;
            m_cnt  <= 0;
        end else begin
            din = (m_cnt >= SS) ? m_hist[(m_cnt - SS) % 16] : 32'h0;
            m_hist[m_cnt % 16] <= gpio_in;
            m_cnt <= m_cnt + 1;
            req = cyc && stb && !m_ack;
            for (int k = 0; k < 4; k++) lane[8*k +: 8] = {8{sel[k]}};
            wv = dat_i & lane;
            case (adr[4:2])
                3'd0: rd = din;
                3'd1: rd = m_out;
                3'd2: rd = m_dir;
`ifdef GPIO_IRQ_EN
                3'd3: rd = m_en;
                3'd4: rd = m_pol;
                3'd5: rd = m_stat;
`endif
                default: rd = 32'h0;
            endcase
            m_ack <= req;
            m_dat <= (req && !we) ? rd : 32'h0;
            if (req && we && adr[4:2] == 3'd1) m_out <= (m_out & ~lane) | wv;
            if (req && we && adr[4:2] == 3'd2) m_dir <= (m_dir & ~lane) | wv;
`ifdef GPIO_IRQ_EN
            begin
                logic [31:0] st;
                st = m_stat;
                if (req && we && adr[4:2] == 3'd5) st = st & ~wv;
                for (int b = 0; b < 32; b++) begin
                    // pin changed and its new level matches the chosen polarity
                    if (din[b] != m_prev[b] && din[b] == m_pol[b]) st[b] = 1'b1;
                end
                m_stat <= st;
            end
            m_irq  <= ((m_stat & m_en) != 0);
            m_prev <= din;
            if (req && we && adr[4:2] == 3'd3) m_en  <= (m_en  & ~lane) | wv;
            if (req && we && adr[4:2] == 3'd4) m_pol <= (m_pol & ~lane) | wv;
`endif
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_ack",     {31'h0, ack}, {31'h0, m_ack});
            check("cyc_rdata",   dat_o,        m_dat);
            check("cyc_gpio_o",  gpio_o,       m_out);
            check("cyc_gpio_oe", gpio_oe,      m_dir);
            check("cyc_irq",     {31'h0, irq}, {31'h0, m_irq});
        end
    end

    // One bus transfer; returns just after the negedge following the ack cycle.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] r);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        @(negedge clk);
        check("xfer_ack_latency", {31'h0, ack}, 32'h1);
        r = dat_o;
        $display("xfer we=%0d adr=%02h wdat=%08h sel=%h rdat=%08h", w, a[7:0], d, s, r);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic [31:0] irq_reg_exp;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_i = '0; sel = '0; gpio_in = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_ack",     {31'h0, ack}, 32'h0);
        check("rst_rdata",   dat_o,        32'h0);
        check("rst_gpio_o",  gpio_o,       ORST);
        check("rst_gpio_oe", gpio_oe,      32'h0);
        check("rst_irq",     {31'h0, irq}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Read all offsets after reset.
        for (int a = 0; a < 8; a++) begin
            xfer(1'b0, 32'(a * 4), 32'h0, 4'hF, rd);
            check($sformatf("reset_read_%0d", a), rd, (a == 1) ? ORST : 32'h0);
        end

        // Full-width writes to DIR and DATA_OUT.
        xfer(1'b1, 32'h08, 32'h0000_FFFF, 4'hF, rd);
        xfer(1'b1, 32'h04, 32'hA5A5_A5A5, 4'hF, rd);
        check("wr_gpio_oe", gpio_oe, 32'h0000_FFFF);
        check("wr_gpio_o",  gpio_o,  32'hA5A5_A5A5);

        // Single byte lane over zero; upper address bits must be ignored.
        xfer(1'b1, 32'hFFFF_FF04, 32'h0, 4'hF, rd);
        xfer(1'b1, 32'h04, 32'h1234_5678, 4'b0100, rd);
        xfer(1'b0, 32'h04, 32'h0, 4'hF, rd);
        check("byte_lane_read", rd, 32'h0034_0000);
        xfer(1'b1, 32'h04, 32'hFFFF_FFFF, 4'h0, rd);
        xfer(1'b0, 32'h04, 32'h0, 4'hF, rd);
        check("sel_zero_no_effect", rd, 32'h0034_0000);

`ifdef GPIO_IRQ_EN
        irq_reg_exp = 32'h1;
`else
        irq_reg_exp = 32'h0;
`endif
        // Interrupt path (reads 0 and stays idle when the feature is absent).
        xfer(1'b1, 32'h0C, 32'h1, 4'hF, rd);
        xfer(1'b1, 32'h10, 32'h1, 4'hF, rd);
        xfer(1'b0, 32'h0C, 32'h0, 4'hF, rd);
        check("int_en_read", rd, irq_reg_exp);
        gpio_in[0] = 1'b1;
        repeat (SS + 2) @(negedge clk);
        check("irq_on_rise", {31'h0, irq}, irq_reg_exp);
        xfer(1'b0, 32'h14, 32'h0, 4'hF, rd);
        check("status_after_rise", rd, irq_reg_exp);
        xfer(1'b1, 32'h14, 32'h1, 4'hF, rd);
        check("irq_after_w1c", {31'h0, irq}, 32'h0);
        gpio_in[0] = 1'b0;
        repeat (SS + 3) @(negedge clk);
        xfer(1'b0, 32'h14, 32'h0, 4'hF, rd);
        check("status_fall_pol1", rd, 32'h0);

        // W1C landing on the same edge as a new rising edge: set wins.
        gpio_in[0] = 1'b1;
        repeat (SS) @(negedge clk);
        xfer(1'b1, 32'h14, 32'h1, 4'hF, rd);
        xfer(1'b0, 32'h14, 32'h0, 4'hF, rd);
        check("w1c_vs_edge", rd, irq_reg_exp);
        xfer(1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF, rd);
        gpio_in[0] = 1'b0;
        repeat (SS + 3) @(negedge clk);

        // Held request: ack on alternate cycles.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h04; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("held_ack_%0d", i), {31'h0, ack}, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);

        // Reset on the request edge cancels the ack and the write.
        xfer(1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, rd);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h04; dat_i = 32'h0000_0055; sel = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ack",     {31'h0, ack}, 32'h0);
        check("rst_mid_gpio_o",  gpio_o,       ORST);
        check("rst_mid_gpio_oe", gpio_oe,      32'h0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);

        // Randomised traffic, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc   = ($urandom_range(0, 3) != 0);
            stb   = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1) == 1;
            adr   = $urandom;
            dat_i = $urandom;
            sel   = 4'($urandom);
            if ($urandom_range(0, 5) == 0) gpio_in = gpio_in ^ (32'h1 << $urandom_range(0, 31));
            if ($urandom_range(0, 40) == 0) gpio_in = $urandom;
            rst   = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
